phr_fcs_deframer: RTL and testbench

//  Consumes the dewhitened byte stream of the receive chain (byte, 2-bit phase code, end-of-frame flag).

---
 rtl/phr_fcs_deframer_pkg.sv | 21 ++
 rtl/phr_fcs_deframer_crc16.sv | 21 ++
 rtl/phr_fcs_deframer.sv | 194 +++++++++++++++++++
 tb/tb_phr_fcs_deframer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phr_fcs_deframer_pkg.sv
// Shared receive-chain definitions: byte_type codes, CRC-16 constants and deframer FSM states.
package phr_fcs_deframer_pkg;

   typedef enum logic [1:0] {
      BT_NONE = 2'd0,
      BT_PHR  = 2'd1,
      BT_PSDU = 2'd2,
      BT_LAST = 2'd3
   } byte_type_e;

   localparam logic [15:0] CRC16_POLY_R = 16'h8408;
   localparam logic [15:0] CRC16_INIT   = 16'h0000;
   localparam int          PHR_BYTES    = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PHR1 = 2'd1,
      ST_BODY = 2'd2
   } state_e;

endpackage

// File: rtl/phr_fcs_deframer_crc16.sv
// Combinational reflected CRC-16 update of one byte, bit0 first.
module crc16_byte
   import phr_fcs_deframer_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   logic [15:0] c_work;

   always_comb begin
      c_work = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c_work[0] ^ data_in[i]) c_work = (c_work >> 1) ^ CRC16_POLY_R;
         else                        c_work = c_work >> 1;
      end
      crc_out = c_work;
   end

endmodule

// File: rtl/phr_fcs_deframer.sv
// PHR capture, PSDU length check, CRC-16 check and FCS strip for the receive chain.
// Valid/strobe semantics: byte_type != 0 is a 1-clk strobe, no backpressure; all outputs registered.
module phr_fcs_deframer
   import phr_fcs_deframer_pkg::*;
#(
   parameter int FCS_BYTES   = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] byte_in,
   input  logic [1:0] byte_type,
   input  logic       frame_end,
   output logic       phr_valid,
   output logic [7:0] phr_flags,
   output logic [7:0] phr_len,
   output logic [7:0] payload_data,
   output logic       payload_valid,
   output logic       payload_last,
   output logic       frame_done,
   output logic       crc_ok,
   output logic       len_err,
   output logic       seq_err,
   output logic       timeout_err
);

   localparam int GW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

   state_e      state, state_n;
   byte_type_e  bt;
   logic [GW-1:0] gap_cnt;
   logic [15:0] crc, crc_next, crc_final;
   logic [7:0]  cnt, cnt_inc, cnt_final;
   logic [7:0]  d0, d1;
   logic [1:0]  fill;
   logic        strobe, is_psdu, gap_hit, len_bad;
   logic        start, take_len, body_byte, close, abort_seq, abort_to;

   assign bt      = byte_type_e'(byte_type);
   assign strobe  = (bt != BT_NONE);
   assign is_psdu = (bt == BT_PSDU) || (bt == BT_LAST);
   assign gap_hit = (state != ST_IDLE) && !strobe && (gap_cnt == GAP_LAST);

   crc16_byte u_crc (
      .crc_in  (crc),
      .data_in (byte_in),
      .crc_out (crc_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      start     = 1'b0;
      take_len  = 1'b0;
      body_byte = 1'b0;
      close     = 1'b0;
      abort_seq = 1'b0;
      abort_to  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bt == BT_PHR) begin
               start   = 1'b1;
               state_n = ST_PHR1;
            end
         end
         ST_PHR1: begin
            if (frame_end || is_psdu) begin
               abort_seq = 1'b1;
               state_n   = ST_IDLE;
            end else if (bt == BT_PHR) begin
               take_len = 1'b1;
               state_n  = ST_BODY;
            end else if (gap_hit) begin
               abort_to = 1'b1;
               state_n  = ST_IDLE;
            end
         end
         ST_BODY: begin
            // A new PHR inside a body aborts the old frame and opens the next one.
            if (bt == BT_PHR) begin
               abort_seq = 1'b1;
               start     = 1'b1;
               state_n   = ST_PHR1;
            end else begin
               body_byte = is_psdu;
               if (frame_end) begin
                  close   = 1'b1;
                  state_n = ST_IDLE;
               end else if (gap_hit) begin
                  abort_to = 1'b1;
                  state_n  = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Closing status must include the byte arriving with frame_end.
   assign cnt_inc   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   assign cnt_final = body_byte ? cnt_inc : cnt;
   assign crc_final = body_byte ? crc_next : crc;
   assign len_bad   = (cnt_final != phr_len) || (cnt_final < 8'(FCS_BYTES));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phr_valid     <= 1'b0;
         phr_flags     <= '0;
         phr_len       <= '0;
         payload_data  <= '0;
         payload_valid <= 1'b0;
         payload_last  <= 1'b0;
         frame_done    <= 1'b0;
         crc_ok        <= 1'b0;
         len_err       <= 1'b0;
         seq_err       <= 1'b0;
         timeout_err   <= 1'b0;
         gap_cnt       <= '0;
         crc           <= CRC16_INIT;
         cnt           <= '0;
         d0            <= '0;
         d1            <= '0;
         fill          <= '0;
      end else begin
         phr_valid     <= 1'b0;
         payload_valid <= 1'b0;
         payload_last  <= 1'b0;
         frame_done    <= 1'b0;

         if (state_n == ST_IDLE || strobe) gap_cnt <= '0;
         else                              gap_cnt <= gap_cnt + 1'b1;

         if (start) begin
            phr_flags <= byte_in;
            crc       <= CRC16_INIT;
            cnt       <= '0;
            fill      <= '0;
            d0        <= '0;
            d1        <= '0;
         end

         if (take_len) begin
            phr_len   <= byte_in;
            phr_valid <= 1'b1;
         end

         // Two-byte delay line: the FCS bytes never reach the output.
         if (body_byte) begin
            crc <= crc_next;
            cnt <= cnt_inc;
            d0  <= byte_in;
            d1  <= d0;
            if (fill == 2'd2) begin
               payload_valid <= 1'b1;
               payload_data  <= d1;
               payload_last  <= frame_end;
            end else begin
               fill <= fill + 2'd1;
            end
         end

         if (abort_seq) begin
            frame_done  <= 1'b1;
            crc_ok      <= 1'b0;
            len_err     <= 1'b0;
            seq_err     <= 1'b1;
            timeout_err <= 1'b0;
         end else if (abort_to) begin
            frame_done  <= 1'b1;
            crc_ok      <= 1'b0;
            len_err     <= 1'b0;
            seq_err     <= 1'b0;
            timeout_err <= 1'b1;
         end else if (close) begin
            frame_done  <= 1'b1;
            crc_ok      <= !len_bad && (crc_final == 16'h0000);
            len_err     <= len_bad;
            seq_err     <= 1'b0;
            timeout_err <= 1'b0;
         end else if (start) begin
            crc_ok      <= 1'b0;
            len_err     <= 1'b0;
            seq_err     <= 1'b0;
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_phr_fcs_deframer.sv
// Self-checking bench for phr_fcs_deframer: payload scoreboard plus per-scenario status checks.
module tb_phr_fcs_deframer;

   localparam int TIMEOUT_CYC = 1024;

   logic       clk;
   logic       rst_n;
   logic [7:0] byte_in;
   logic [1:0] byte_type;
   logic       frame_end;
   logic       phr_valid;
   logic [7:0] phr_flags;
   logic [7:0] phr_len;
   logic [7:0] payload_data;
   logic       payload_valid;
   logic       payload_last;
   logic       frame_done;
   logic       crc_ok;
   logic       len_err;
   logic       seq_err;
   logic       timeout_err;

   int errors = 0;
   int checks = 0;

   logic [8:0] exp_q[$];
   logic [8:0] obs_mem[0:4095];
   int         obs_wr = 0;
   int         obs_rd = 0;
   int         done_cnt = 0;
   int         phr_cnt = 0;

   logic [7:0] pl[0:255];
   int         pl_n;

   phr_fcs_deframer #(.FCS_BYTES(2), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .byte_in       (byte_in),
      .byte_type     (byte_type),
      .frame_end     (frame_end),
      .phr_valid     (phr_valid),
      .phr_flags     (phr_flags),
      .phr_len       (phr_len),
      .payload_data  (payload_data),
      .payload_valid (payload_valid),
      .payload_last  (payload_last),
      .frame_done    (frame_done),
      .crc_ok        (crc_ok),
      .len_err       (len_err),
      .seq_err       (seq_err),
      .timeout_err   (timeout_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // output monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (payload_valid) begin
         obs_mem[obs_wr % 4096] <= {payload_last, payload_data};
         obs_wr <= obs_wr + 1;
      end
      if (frame_done) done_cnt <= done_cnt + 1;
      if (phr_valid)  phr_cnt  <= phr_cnt + 1;
   end

   function automatic logic [15:0] model_crc(input int n);
      logic [15:0] c;
      c = 16'h0000;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < 8; b++)
            c = (c[0] ^ pl[i][b]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      return c;
   endfunction

   // driver tasks
   task automatic send_byte(input logic [7:0] b, input logic [1:0] t, input logic fe);
      @(posedge clk); #1;
      byte_in = b; byte_type = t; frame_end = fe;
      @(posedge clk); #1;
      byte_type = 2'd0; frame_end = 1'b0;
      repeat (7) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] flags, input logic [7:0] len,
                             input logic [15:0] fcs_xor);
      logic [15:0] fcs;
      fcs = model_crc(pl_n) ^ fcs_xor;
      send_byte(flags, 2'd1, 1'b0);
      send_byte(len, 2'd1, 1'b0);
      for (int i = 0; i < pl_n; i++) begin
         exp_q.push_back({(i == pl_n - 1), pl[i]});
         send_byte(pl[i], 2'd2, 1'b0);
      end
      send_byte(fcs[7:0], 2'd2, 1'b0);
      send_byte(fcs[15:8], 2'd3, 1'b1);
   endtask

   task automatic load_ascii_payload();
      pl_n = 9;
      for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
   endtask

   task automatic wait_done(input int base, input int budget, input string name);
      int k;
      k = 0;
      while (done_cnt == base && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (done_cnt !== base + 1) begin
         errors++;
         $display("FAIL %s frame_done count: got %0d want %0d", name, done_cnt - base, 1);
      end
   endtask

   // scoreboard: compare observed payload strobes against the expected queue
   task automatic score_payload(input string name);
      logic [8:0] e;
      checks++;
      if ((obs_wr - obs_rd) !== exp_q.size()) begin
         errors++;
         $display("FAIL %s payload count: got %0d want %0d", name, obs_wr - obs_rd, exp_q.size());
      end
      while (exp_q.size() > 0 && obs_rd < obs_wr) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_mem[obs_rd % 4096] !== e) begin
            errors++;
            $display("FAIL %s payload {last,data}: got %03h want %03h", name, obs_mem[obs_rd % 4096], e);
         end
         obs_rd++;
      end
      exp_q.delete();
      obs_rd = obs_wr;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; byte_in = '0; byte_type = 2'd0; frame_end = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({phr_valid, phr_flags, phr_len, payload_data, payload_valid, payload_last,
           frame_done, crc_ok, len_err, seq_err, timeout_err} !== 36'h0) begin
         errors++;
         $display("FAIL reset outputs: got nonzero want all 0");
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_good_frame();
      int base, pbase;
      base = done_cnt; pbase = phr_cnt;
      load_ascii_payload();
      send_frame(8'h00, 8'd11, 16'h0000);
      wait_done(base, 50, "good");
      score_payload("good");
      checks++;
      if (phr_cnt - pbase !== 1 || phr_len !== 8'd11 || phr_flags !== 8'h00) begin
         errors++;
         $display("FAIL good phr: got cnt=%0d len=%0d flags=%0h want 1 11 0", phr_cnt - pbase, phr_len, phr_flags);
      end
      checks++;
      if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b1000) begin
         errors++;
         $display("FAIL good status: got %b want 1000", {crc_ok, len_err, seq_err, timeout_err});
      end
   endtask

   task automatic test_bad_crc();
      int base;
      base = done_cnt;
      load_ascii_payload();
      send_frame(8'h5A, 8'd11, 16'h0100);
      wait_done(base, 50, "bad_crc");
      score_payload("bad_crc");
      checks++;
      if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b0000) begin
         errors++;
         $display("FAIL bad_crc status: got %b want 0000", {crc_ok, len_err, seq_err, timeout_err});
      end
      checks++;
      if (phr_flags !== 8'h5A) begin
         errors++;
         $display("FAIL bad_crc phr_flags: got %0h want 5a", phr_flags);
      end
   endtask

   task automatic test_len_err();
      int base;
      base = done_cnt;
      load_ascii_payload();
      send_frame(8'h00, 8'd12, 16'h0000);
      wait_done(base, 50, "len");
      score_payload("len");
      checks++;
      if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b0100) begin
         errors++;
         $display("FAIL len status: got %b want 0100", {crc_ok, len_err, seq_err, timeout_err});
      end
   endtask

   task automatic test_empty();
      int base;
      base = done_cnt;
      pl_n = 0;
      send_frame(8'h00, 8'd2, 16'h0000);
      wait_done(base, 50, "empty");
      score_payload("empty");
      checks++;
      if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b1000) begin
         errors++;
         $display("FAIL empty status: got %b want 1000", {crc_ok, len_err, seq_err, timeout_err});
      end
   endtask

   task automatic test_seq_err();
      int base;
      base = done_cnt;
      send_byte(8'h00, 2'd1, 1'b0);
      send_byte(8'h44, 2'd2, 1'b0);
      wait_done(base, 50, "seq");
      score_payload("seq");
      checks++;
      if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b0010) begin
         errors++;
         $display("FAIL seq status: got %b want 0010", {crc_ok, len_err, seq_err, timeout_err});
      end
      base = done_cnt;
      load_ascii_payload();
      send_frame(8'h00, 8'd11, 16'h0000);
      wait_done(base, 50, "seq_recover");
      score_payload("seq_recover");
      checks++;
      if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b1000) begin
         errors++;
         $display("FAIL seq_recover status: got %b want 1000", {crc_ok, len_err, seq_err, timeout_err});
      end
   endtask

   task automatic test_timeout();
      int base;
      base = done_cnt;
      send_byte(8'h00, 2'd1, 1'b0);
      send_byte(8'd11, 2'd1, 1'b0);
      exp_q.push_back({1'b0, 8'h31});
      send_byte(8'h31, 2'd2, 1'b0);
      send_byte(8'h32, 2'd2, 1'b0);
      send_byte(8'h33, 2'd2, 1'b0);
      wait_done(base, TIMEOUT_CYC + 50, "timeout");
      score_payload("timeout");
      checks++;
      if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b0001) begin
         errors++;
         $display("FAIL timeout status: got %b want 0001", {crc_ok, len_err, seq_err, timeout_err});
      end
   endtask

   task automatic test_reset_mid();
      int base;
      base = done_cnt;
      send_byte(8'h00, 2'd1, 1'b0);
      send_byte(8'd11, 2'd1, 1'b0);
      exp_q.push_back({1'b0, 8'h31});
      send_byte(8'h31, 2'd2, 1'b0);
      send_byte(8'h32, 2'd2, 1'b0);
      send_byte(8'h33, 2'd2, 1'b0);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({phr_valid, phr_flags, phr_len, payload_valid, payload_last,
           frame_done, crc_ok, len_err, seq_err, timeout_err} !== 28'h0) begin
         errors++;
         $display("FAIL reset_mid outputs: got nonzero want all 0");
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (done_cnt !== base) begin
         errors++;
         $display("FAIL reset_mid frame_done: got %0d want 0", done_cnt - base);
      end
      score_payload("reset_mid");
      base = done_cnt;
      load_ascii_payload();
      send_frame(8'h00, 8'd11, 16'h0000);
      wait_done(base, 50, "reset_recover");
      score_payload("reset_recover");
      checks++;
      if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_recover status: got %b want 1000", {crc_ok, len_err, seq_err, timeout_err});
      end
   endtask

   task automatic test_back_to_back();
      int base;
      for (int f = 0; f < 4; f++) begin
         base = done_cnt;
         pl_n = int'($urandom_range(1, 20));
         for (int i = 0; i < pl_n; i++) pl[i] = 8'($urandom_range(0, 255));
         send_frame(8'(f), 8'(pl_n + 2), 16'h0000);
         wait_done(base, 50, "b2b");
         score_payload("b2b");
         checks++;
         if ({crc_ok, len_err, seq_err, timeout_err} !== 4'b1000 || phr_len !== 8'(pl_n + 2)) begin
            errors++;
            $display("FAIL b2b status: got %b len=%0d want 1000 len=%0d",
                     {crc_ok, len_err, seq_err, timeout_err}, phr_len, pl_n + 2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_crc();
      test_len_err();
      test_empty();
      test_seq_err();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
